// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters.
// One op is in flight at a time: IDLE (grant) -> EXEC (compute) -> RESP (return).
module alu_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [4*NUM_REQ-1:0]          req_opcode,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_zero,
    output logic                          rsp_carry,
    output logic                          rsp_err,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    // Legal opcodes 0..7; opcode[3] set marks an illegal request.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    state_t                  r_state;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         r_grant;
    logic [3:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_zero;
    logic                    r_carry;
    logic                    r_err;
    logic [ID_W-1:0]         r_id;

    logic [2*NUM_REQ-1:0]    w_dbl;
    logic [NUM_REQ-1:0]      w_rot;
    logic                    w_found;
    logic [ID_W-1:0]         w_gidx;
    logic                    w_accept;
    logic [3:0]              w_sel_op;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_b;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_carry;

    // Rotate the valids so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found = 1'b0;
        w_gidx  = '0;
        w_dbl   = {req_valid, req_valid} >> r_rr_ptr;
        w_rot   = w_dbl[NUM_REQ-1:0];
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_gidx  = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign req_ready = (w_accept && !ARESET) ? (NUM_REQ'(1) << w_gidx) : '0;

    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gidx == ID_W'(i)) begin
                w_sel_op = req_opcode[i*4 +: 4];
                w_sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Shared ALU core working on the captured operands.
    always_comb begin
        w_sum    = {1'b0, r_a} + {1'b0, r_b};
        w_result = '0;
        w_carry  = 1'b0;
        if (!r_op[3]) begin
            case (r_op[2:0])
                OP_ADD: begin
                    w_result = w_sum[DATA_WIDTH-1:0];
                    w_carry  = w_sum[DATA_WIDTH];
                end
                OP_SUB: begin
                    w_result = r_a - r_b;
                    w_carry  = (r_a < r_b);
                end
                OP_AND:  w_result = r_a & r_b;
                OP_OR:   w_result = r_a | r_b;
                OP_XOR:  w_result = r_a ^ r_b;
                OP_NOT:  w_result = ~r_a;
                OP_SHL:  w_result = r_a << r_b[4:0];
                OP_SHR:  w_result = r_a >> r_b[4:0];
                default: w_result = '0;
            endcase
        end
    end

    // NOTE: operand and grant capture registers carry no reset; they are only read after a capture.
    always_ff @(posedge ACLK) begin
        if (w_accept) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_grant <= w_gidx;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
            r_id        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result    <= w_result;
                    r_zero      <= (w_result == '0);
                    r_carry     <= w_carry;
                    r_err       <= r_op[3];
                    r_id        <= r_grant;
                    r_rsp_valid <= NUM_REQ'(1) << r_grant;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // Fairness pointer moves only once the response is taken.
                    if (rsp_ready[r_grant]) begin
                        r_rsp_valid <= '0;
                        r_rr_ptr    <= (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + ID_W'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_carry  = r_carry;
    assign rsp_err    = r_err;
    assign rsp_id     = r_id;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one instance of the team's combinational ALU core (opcodes ADD/SUB/AND/OR/XOR/NOT/SHL/SHR) among NUM_REQ requesters. Requests are arbitrated round-robin, and each requester uses a valid/ready request channel and a valid/ready response channel. Operands are captured in a register stage and the result and flags are registered before they are returned. Sits between the AXI-side register front-ends (one per master) and the shared ALU datapath.

Parameters:
DATA_WIDTH, 32, operand/result width; must be >= 32 (shift amount is operand_b[4:0])
NUM_REQ, 4, number of requesters; 2..8
ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ), with a minimum of 1

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
req_opcode  in  4*NUM_REQ  opcode, slice i belongs to requester i
req_a  in  DATA_WIDTH*NUM_REQ  operand A slices
req_b  in  DATA_WIDTH*NUM_REQ  operand B slices
rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_result  out  DATA_WIDTH  result of the current response
rsp_zero  out  1  zero flag
rsp_carry  out  1  carry (ADD) / borrow (SUB), otherwise 0
rsp_err  out  1  opcode was 8..15
rsp_id  out  ID_W  index of the requester being answered
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (ARESET high at an edge) forces state=IDLE and rr_ptr=0.
- Reset values: rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_carry=0, rsp_err=0, rsp_id=0, busy=0. req_ready=0 while ARESET is high.
- Reset mid-operation aborts the in-flight op. No response is ever issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant g = first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle only, so the handshake completes that cycle.
  - On the edge, capture opcode/a/b of g and g itself, then go to EXEC.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- req_ready is 0 in EXEC and RESP. Only one op is in flight at a time.
- EXEC (1 cycle):
  - Drive the captured operands through the ALU function.
  - Register result, zero, carry, and err=(opcode[3]==1); set rsp_id=g.
  - Go to RESP.
- RESP:
  - rsp_valid[g]=1. rsp_result, flags and rsp_id are held stable until rsp_ready[g]=1.
  - On the accepting edge: rsp_valid goes to 0, rr_ptr=(g+1) mod NUM_REQ, state goes to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency: request accepted at edge T, rsp_valid high from cycle T+1 through the acceptance edge. Minimum 3 cycles per op (IDLE, EXEC, RESP).
- ALU arithmetic, all modulo 2^DATA_WIDTH:
  - ADD: {carry,result}=a+b.
  - SUB: result=a-b; carry=(a<b) unsigned.
  - AND/OR/XOR: bitwise.
  - NOT: result=~a (b ignored).
  - SHL/SHR: logical shift of a by b[4:0].
  - Opcodes 8..15: result=0, carry=0, err=1.
  - zero=(result==0) for all opcodes, including illegal ones.
- rr_ptr advances only on response completion. A requester that drops req_valid before it is granted simply loses its turn; there is no penalty.
- req_valid may be asserted in any state. Requests are held by the requester and are not dropped by the block.

Test Plan:
1. Reset, then requester 0 sends ADD a=0xFFFFFFFF b=0x00000001 with rsp_ready=1 -> req_ready[0] high for 1 cycle; rsp_valid[0] at T+1; result=0, zero=1, carry=1, err=0, rsp_id=0.
2. Requester 2 sends SUB a=3 b=5 and holds rsp_ready=0 for 4 cycles -> rsp_valid[2] and result=0xFFFFFFFE, carry=1, zero=0 stay stable for 4 cycles; the bus is released one edge after rsp_ready[2]=1.
3. All 4 req_valid held high with rsp_ready all 1 -> grants in order 0,1,2,3,0 with one op every 3 cycles; rsp_id follows the same sequence.
4. Requester 1 sends SHL a=0x1 b=0x25 (shift 5), then SHR a=0x80000000 b=31 -> results 0x20 and 0x1; carry=0.
5. Requester 3 sends opcode 0xA -> result=0, zero=1, err=1, carry=0.
6. ARESET asserted during EXEC of a pending op -> no rsp_valid follows; busy=0 next cycle; the next request from requester 1 is granted starting from rr_ptr=0.
